mem_responder: RTL and testbench

- Memory-side responder for the CPU's data/instruction load-store path. The CPU acts as initiator.
- Accepts one request at a time over a valid/ready request channel.
- Waits a fixed, configurable number of cycles, then returns read data and status over a valid/ready response channel.
- Supports byte, halfword and word accesses with big-endian lane placement, and backs them with an internal synchronous word array.

---
 rtl/mem_pkg.sv | 31 +++
 rtl/mem_responder_if.sv | 26 ++
 rtl/mem_lane_align.sv | 44 ++++
 rtl/mem_responder.sv | 122 ++++++++++++
 tb/tb_mem_responder.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the memory responder: access sizes, FSM states and the
// alignment rule used when MEM_ALIGN_CHECK_EN is defined.
package mem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11   // behaves as a word access
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    localparam int DATA_WIDTH = 32;

    // Halfwords must sit on an even byte, words on a multiple of four.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic mis;
        case (size_e'(size))
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = offset[0];
            default:   mis = |offset;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response channel between the CPU load-store path (master) and the
// memory responder (slave).
interface mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mem_lane_align.sv
// Big-endian lane steering: merges store data into the addressed lane of a
// stored word and extracts the addressed lane as right-justified load data.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] word_in,
    input  logic [31:0] wdata,
    output logic [31:0] wr_word,
    output logic [31:0] rd_data
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        wr_word = word_in;
        rd_data = '0;
        case (size_e'(size))
            SIZE_BYTE: begin
                case (offset)
                    2'd0: begin rd_data[7:0] = word_in[31:24]; wr_word[31:24] = wdata[7:0]; end
                    2'd1: begin rd_data[7:0] = word_in[23:16]; wr_word[23:16] = wdata[7:0]; end
                    2'd2: begin rd_data[7:0] = word_in[15:8];  wr_word[15:8]  = wdata[7:0]; end
                    default: begin rd_data[7:0] = word_in[7:0]; wr_word[7:0] = wdata[7:0]; end
                endcase
            end
            SIZE_HALF: begin
                // Only offset[1] selects the half; offset[0] is dropped here.
                if (offset[1]) begin
                    rd_data[15:0] = word_in[15:0];
                    wr_word[15:0] = wdata[15:0];
                end else begin
                    rd_data[15:0]  = word_in[31:16];
                    wr_word[31:16] = wdata[15:0];
                end
            end
            default: begin
                rd_data = word_in;
                wr_word = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with fixed LATENCY and a word array.
// Define MEM_ALIGN_CHECK_EN to fault misaligned half/word accesses via rsp_err.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input logic           clk,
    input logic           reset,
    mem_responder_if.slave bus
);

    localparam int         DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_e state_q, state_d;
    logic [3:0] cnt_q;

    logic                  write_q;
    logic [1:0]            size_q;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;
    logic                  err_q;

    logic [31:0] mem [DEPTH];

    logic                  accept;
    logic                  resp_entry;
    logic                  fault;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [31:0]           stored_word;
    logic [31:0]           wr_word;
    logic [31:0]           rd_data;
    logic [29-ADDR_WIDTH:0] unused_addr_hi;

    // Upper address bits wrap: only the word index and byte offset are kept.
    assign unused_addr_hi = bus.req_addr[31:ADDR_WIDTH+2];

    assign accept      = (state_q == ST_IDLE) && bus.req_valid;
    assign resp_entry  = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    assign word_idx    = addr_q[ADDR_WIDTH+1:2];
    assign stored_word = mem[word_idx];

`ifdef MEM_ALIGN_CHECK_EN
    assign fault = is_misaligned(size_q, addr_q[1:0]);
`else
    assign fault = 1'b0;
`endif

    mem_lane_align u_lane_align (
        .size    (size_q),
        .offset  (addr_q[1:0]),
        .word_in (stored_word),
        .wdata   (wdata_q),
        .wr_word (wr_word),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Every accept passes through WAIT so the access always uses the captured
    // request and rsp_valid rises exactly LATENCY edges after the accept edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.req_valid)   state_d = ST_WAIT;
            ST_WAIT: if (cnt_q == 4'd0)   state_d = ST_RESP;
            ST_RESP: if (bus.rsp_ready)   state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            write_q <= 1'b0;
            size_q  <= SIZE_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                write_q <= bus.req_write;
                size_q  <= bus.req_size;
                addr_q  <= bus.req_addr[ADDR_WIDTH+1:0];
                wdata_q <= bus.req_wdata;
                cnt_q   <= CNT_LOAD;
            end else if ((state_q == ST_WAIT) && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end

            // Response payload is frozen from RESP entry until the next access.
            if (resp_entry) begin
                rdata_q <= (write_q || fault) ? 32'd0 : rd_data;
                err_q   <= fault;
            end
        end
    end

    // NOTE: the array has no reset; its contents survive reset by design.
    always_ff @(posedge clk) begin
        if (resp_entry && write_q && !fault) begin
            mem[word_idx] <= wr_word;
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (LATENCY=2): vector table plus hand-written
// stall and reset sequences. Expectations follow MEM_ALIGN_CHECK_EN if defined.
module tb_mem_responder;

    typedef struct {
        logic        write;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 22;
    localparam int LAT  = 2;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    mem_responder_if bus ();

    mem_responder #(.ADDR_WIDTH(8), .LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Presents a request at posedge+1, then counts edges until rsp_valid.
    task automatic issue(input logic w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, output int lat);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_size  = sz;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 0;
        while (bus.rsp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic complete();
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    vec_t        vecs [NVEC];
    logic [31:0] prior_40;

    initial begin
        int lat;

`ifdef MEM_ALIGN_CHECK_EN
        prior_40 = 32'h5555_5555;
`else
        prior_40 = 32'h8765_4321;
`endif
        vecs[0]  = '{1'b1, 2'b10, 32'h10,  32'hDEAD_BEEF, 32'h0,         1'b0};
        vecs[1]  = '{1'b0, 2'b10, 32'h10,  32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 2'b10, 32'h10,  32'h1122_3344, 32'h0,         1'b0};
        vecs[3]  = '{1'b1, 2'b00, 32'h11,  32'hFFFF_FFAA, 32'h0,         1'b0};
        vecs[4]  = '{1'b0, 2'b10, 32'h10,  32'h0,         32'h11AA_3344, 1'b0};
        vecs[5]  = '{1'b0, 2'b00, 32'h13,  32'h0,         32'h0000_0044, 1'b0};
        vecs[6]  = '{1'b0, 2'b00, 32'h10,  32'h0,         32'h0000_0011, 1'b0};
        vecs[7]  = '{1'b0, 2'b00, 32'h12,  32'h0,         32'h0000_0033, 1'b0};
        vecs[8]  = '{1'b1, 2'b10, 32'h20,  32'h0,         32'h0,         1'b0};
        vecs[9]  = '{1'b1, 2'b01, 32'h22,  32'h1234_BEEF, 32'h0,         1'b0};
        vecs[10] = '{1'b0, 2'b10, 32'h20,  32'h0,         32'h0000_BEEF, 1'b0};
        vecs[11] = '{1'b0, 2'b01, 32'h22,  32'h0,         32'h0000_BEEF, 1'b0};
        vecs[12] = '{1'b0, 2'b01, 32'h20,  32'h0,         32'h0000_0000, 1'b0};
        vecs[13] = '{1'b1, 2'b01, 32'h20,  32'h0000_CAFE, 32'h0,         1'b0};
        vecs[14] = '{1'b0, 2'b10, 32'h20,  32'h0,         32'hCAFE_BEEF, 1'b0};
        vecs[15] = '{1'b0, 2'b10, 32'h410, 32'h0,         32'h11AA_3344, 1'b0};
        vecs[16] = '{1'b0, 2'b11, 32'hFFFF_FC10, 32'h0,   32'h11AA_3344, 1'b0};
        vecs[17] = '{1'b1, 2'b10, 32'h40,  32'h5555_5555, 32'h0,         1'b0};
`ifdef MEM_ALIGN_CHECK_EN
        vecs[18] = '{1'b1, 2'b10, 32'h42,  32'h8765_4321, 32'h0,         1'b1};
        vecs[19] = '{1'b0, 2'b10, 32'h40,  32'h0,         32'h5555_5555, 1'b0};
        vecs[20] = '{1'b0, 2'b01, 32'h21,  32'h0,         32'h0,         1'b1};
        vecs[21] = '{1'b0, 2'b00, 32'h41,  32'h0,         32'h0000_0055, 1'b0};
`else
        vecs[18] = '{1'b1, 2'b10, 32'h42,  32'h8765_4321, 32'h0,         1'b0};
        vecs[19] = '{1'b0, 2'b10, 32'h40,  32'h0,         32'h8765_4321, 1'b0};
        vecs[20] = '{1'b0, 2'b01, 32'h21,  32'h0,         32'h0000_CAFE, 1'b0};
        vecs[21] = '{1'b0, 2'b00, 32'h41,  32'h0,         32'h0000_0065, 1'b0};
`endif

        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_size  = 2'b00;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset req_ready", 32'(bus.req_ready), 32'd1);
        check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset rsp_rdata", bus.rsp_rdata, 32'd0);
        check("reset rsp_err",   32'(bus.rsp_err), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NVEC; i++) begin
            check($sformatf("v%0d req_ready", i), 32'(bus.req_ready), 32'd1);
            issue(vecs[i].write, vecs[i].size, vecs[i].addr, vecs[i].wdata, lat);
            check($sformatf("v%0d latency", i), 32'(lat), 32'(LAT));
            check($sformatf("v%0d rdata", i), bus.rsp_rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d err", i), 32'(bus.rsp_err), 32'(vecs[i].exp_err));
            complete();
            check($sformatf("v%0d post rsp_valid", i), 32'(bus.rsp_valid), 32'd0);
        end

        // Backpressure: response held for 5 cycles while another request waits.
        issue(1'b0, 2'b10, 32'h10, 32'h0, lat);
        check("stall latency", 32'(lat), 32'(LAT));
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_size  = 2'b10;
        bus.req_addr  = 32'h10;
        bus.req_wdata = 32'h0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("stall%0d rsp_valid", c), 32'(bus.rsp_valid), 32'd1);
            check($sformatf("stall%0d rdata", c), bus.rsp_rdata, 32'h11AA_3344);
            check($sformatf("stall%0d req_ready", c), 32'(bus.req_ready), 32'd0);
        end
        bus.req_valid = 1'b0;
        complete();
        check("stall post rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("stall post req_ready", 32'(bus.req_ready), 32'd1);
        issue(1'b0, 2'b10, 32'h10, 32'h0, lat);
        check("stall no store", bus.rsp_rdata, 32'h11AA_3344);
        complete();

        // Reset while a store sits in WAIT: no response, store dropped.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_size  = 2'b10;
        bus.req_addr  = 32'h40;
        bus.req_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("rstw in wait", 32'(bus.req_ready), 32'd0);
        reset = 1'b1;
        #1;
        check("rstw rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rstw req_ready", 32'(bus.req_ready), 32'd1);
        check("rstw rsp_rdata", bus.rsp_rdata, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check($sformatf("rstw idle%0d rsp_valid", c), 32'(bus.rsp_valid), 32'd0);
        end
        issue(1'b0, 2'b10, 32'h40, 32'h0, lat);
        check("rstw prior value", bus.rsp_rdata, prior_40);
        complete();

        // Reset while a load response is pending.
        issue(1'b0, 2'b10, 32'h10, 32'h0, lat);
        check("rstr rdata", bus.rsp_rdata, 32'h11AA_3344);
        reset = 1'b1;
        #1;
        check("rstr rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rstr rsp_rdata", bus.rsp_rdata, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("rstr req_ready", 32'(bus.req_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
